tiny_dnn_prm_loader: RTL and testbench
======================================

# tiny_dnn_prm_loader

Parametrised weight/bias loader sitting between the input AXI-stream and the array of `tiny_dnn_core` instances. It replaces the fixed 4-lane, 16-core fan-out and the parameter address counters with a block generic in core count, lane count and data width. Streamed parameter beats are written into one group of cores at a time, with registered write strobes. It also adds framing checks (early or missing `src_last`), partial-group loads and a completion pulse.

## Interface
Parameters:
- `F_NUM`, 16, number of cores; must be a multiple of `LANES`.
- `LANES`, 4, data words per stream beat; one word per core of a group.
- `DW`, 16, word width.
- `AW`, 10, core parameter address width.

Ports:
- `clk`  in  1  single clock; everything rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a load; ignored unless in IDLE.
- `bwrite`  in  1  sampled at `start`; 1 = bias load (one word per core), 0 = weight load.
- `ks`  in  AW  sampled at `start`; words per core minus one (weight mode only).
- `ng`  in  log2(F_NUM/LANES) (min 1)  sampled at `start`; active groups minus one.
- `src_valid`  in  1  stream beat valid.
- `src_data`  in  LANES*DW  lane k at bits [k*DW +: DW].
- `src_last`  in  1  final beat of the packet.
- `src_ready`  out  1  beat accepted when `src_valid & src_ready`.
- `wr_en`  out  F_NUM  per-core write strobe, registered.
- `wr_bias`  out  1  qualifies `wr_en` as a bias write.
- `wr_addr`  out  AW  core parameter address, registered.
- `wr_data`  out  LANES*DW  registered beat; core i takes lane i%LANES.
- `busy`  out  1  high in LOAD and DRAIN.
- `done`  out  1  one-cycle pulse at end of load.
- `err`  out  1  sticky framing error; cleared by the next accepted `start`.

## Operation
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE→LOAD on `start`: latch `bwrite`, `ks`, `ng`. Clear `err`, group counter `g`, address counter `a`.
  - LOAD: `src_ready`=1. Each accepted beat writes group `g` at address `a`.
  - Weight mode: `a` increments 0..ks. At ks, `a`←0 and `g`++.
  - Bias mode: `a` stays 0 and `g`++ every beat.
  - Expected beats: (ks+1)*(ng+1) for weights, (ng+1) for bias.
- Final expected beat accepted → DRAIN.
  - If `src_last`=0 on that beat, set `err`.
- `src_last`=1 on an earlier beat: write it, set `err`, go to DRAIN. Remaining groups are not written.
- DRAIN: `src_ready`=0 for one cycle, `done` pulses, then IDLE.
- Write stage, registered from the accepted beat:
  - `wr_en[i]`=1 iff `i/LANES`==`g`.
  - `wr_addr`=`a`, `wr_data`=`src_data`, `wr_bias`=latched `bwrite`.
  - `wr_en`=0 on every cycle without an accepted beat. `wr_addr`, `wr_data` and `wr_bias` hold their last values.
- A `start` in LOAD or DRAIN is ignored.
- `ng` above F_NUM/LANES−1 saturates to F_NUM/LANES−1.
- Counters are exact-width; no wrap occurs within a legal load.

## Timing
- Reset values: state IDLE, `src_ready`=0, `wr_en`=0, `wr_bias`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0.
- `start` at cycle t → `src_ready`=1 and `busy`=1 from t+1.
- Beat accepted at cycle t → `wr_*` valid during t+1. Latency is 1 cycle and throughput is 1 beat/cycle.
- Final beat at t → `src_ready`=0 at t+1, `done`=1 at t+1, write of the final beat at t+1, IDLE at t+2.
- `src_valid` low stalls the counters; there is no timeout.
- Reset asserted mid-load: all outputs go to reset values immediately (asynchronous), including an in-flight `wr_en`. The partial load is abandoned.

## Test plan
- Weight load, F_NUM=16, LANES=4, ks=2, ng=3: 12 beats, `src_last` on beat 12.
  - Expected: `wr_en` = 0x000F at a=0,1,2, then 0x00F0, 0x0F00, 0xF000.
  - `done` one cycle after beat 12; `err`=0.
- Bias load, `bwrite`=1, ng=1: 2 beats.
  - Expected: `wr_bias`=1, `wr_addr`=0, `wr_en` = 0x000F then 0x00F0, `done`; `err`=0.
- Early `src_last` on beat 5 of the 12-beat load.
  - Expected: 5 writes, `err`=1, `done` one cycle after beat 5, no further `wr_en`.
- Missing `src_last` on beat 12.
  - Expected: all 12 writes, `err`=1, `done`.
  - Next `start` clears `err`.
- Randomised `src_valid` gaps at 50% duty on the 12-beat load.
  - Expected: identical write sequence; `wr_en` is 0 on every gap cycle.
- `rst_n` low after beat 6 while `wr_en` is high.
  - Expected: `wr_en`=0 asynchronously.
  - After release: IDLE, `src_ready`=0; a fresh load completes normally.

Source files
------------

// File: rtl/tiny_dnn_prm_loader.sv
// Parameter loader: streams weight/bias beats into one LANES-wide group of cores at a time.
// Latency: an accepted beat appears on wr_* in the next cycle; throughput is one beat per cycle.
// Backpressure: src_ready is high only in LOAD; it drops for the one DRAIN cycle after the last beat.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, bwrite, ks, ng   load request plus its mode, words-per-core-1, groups-1
//   src_valid/data/last/ready   input parameter stream
//   wr_en/bias/addr/data    registered per-core write port
//   busy, done, err         status: load in progress, end-of-load pulse, sticky framing error
module tiny_dnn_prm_loader #(
    parameter int F_NUM = 16,
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 10,
    localparam int GW   = F_NUM / LANES,
    localparam int NGW  = (GW > 1) ? $clog2(GW) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                bwrite,
    input  logic [AW-1:0]       ks,
    input  logic [NGW-1:0]      ng,
    input  logic                src_valid,
    input  logic [LANES*DW-1:0] src_data,
    input  logic                src_last,
    output logic                src_ready,
    output logic [F_NUM-1:0]    wr_en,
    output logic                wr_bias,
    output logic [AW-1:0]       wr_addr,
    output logic [LANES*DW-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [NGW-1:0] NG_MAX = NGW'(GW - 1);

    state_t              state_q, state_d;
    logic                bias_q, bias_d;
    logic [AW-1:0]       ks_q, ks_d;
    logic [NGW-1:0]      ng_q, ng_d;
    logic [NGW-1:0]      g_q, g_d;
    logic [AW-1:0]       a_q, a_d;
    logic                err_q, err_d;
    logic [F_NUM-1:0]    wr_en_q, wr_en_d;
    logic                wr_bias_q, wr_bias_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [LANES*DW-1:0] wr_data_q, wr_data_d;

    logic [F_NUM-1:0]    grp_mask;
    logic                last_word;
    logic                final_beat;

    // One strobe per core; core i belongs to group i/LANES.
    always_comb begin
        grp_mask = '0;
        for (int i = 0; i < F_NUM; i++) begin
            grp_mask[i] = (g_q == NGW'(i / LANES));
        end
    end

    // Bias loads carry exactly one word per core, so every beat closes a group.
    assign last_word  = bias_q || (a_q == ks_q);
    assign final_beat = last_word && (g_q == ng_q);

    always_comb begin
        state_d   = state_q;
        bias_d    = bias_q;
        ks_d      = ks_q;
        ng_d      = ng_q;
        g_d       = g_q;
        a_d       = a_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_bias_d = wr_bias_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    bias_d  = bwrite;
                    ks_d    = ks;
                    ng_d    = (ng > NG_MAX) ? NG_MAX : ng;
                    g_d     = '0;
                    a_d     = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (src_valid) begin
                    wr_en_d   = grp_mask;
                    wr_bias_d = bias_q;
                    wr_addr_d = a_q;
                    wr_data_d = src_data;
                    if (final_beat) begin
                        state_d = DRAIN;
                        if (!src_last) begin
                            err_d = 1'b1;
                        end
                    end else if (src_last) begin
                        // Packet ended early: the remaining groups keep their old contents.
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end else if (last_word) begin
                        a_d = '0;
                        g_d = g_q + 1'b1;
                    end else begin
                        a_d = a_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bias_q    <= 1'b0;
            ks_q      <= '0;
            ng_q      <= '0;
            g_q       <= '0;
            a_q       <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_bias_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bias_q    <= bias_d;
            ks_q      <= ks_d;
            ng_q      <= ng_d;
            g_q       <= g_d;
            a_q       <= a_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_bias_q <= wr_bias_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign src_ready = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN);
    assign err       = err_q;
    assign wr_en     = wr_en_q;
    assign wr_bias   = wr_bias_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_tiny_dnn_prm_loader.sv
// Scoreboard bench for tiny_dnn_prm_loader: expected writes and completions are queued by the
// stimulus; a negedge monitor pops them whenever the DUT writes or pulses done.
module tb_tiny_dnn_prm_loader;

    localparam int F_NUM = 16;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 10;

    typedef struct packed {
        logic [F_NUM-1:0]    en;
        logic                bias;
        logic [AW-1:0]       addr;
        logic [LANES*DW-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                bwrite = 1'b0;
    logic [AW-1:0]       ks = '0;
    logic [1:0]          ng = '0;
    logic                src_valid = 1'b0;
    logic [LANES*DW-1:0] src_data = '0;
    logic                src_last = 1'b0;
    logic                src_ready;
    logic [F_NUM-1:0]    wr_en;
    logic                wr_bias;
    logic [AW-1:0]       wr_addr;
    logic [LANES*DW-1:0] wr_data;
    logic                busy;
    logic                done;
    logic                err;

    tiny_dnn_prm_loader #(.F_NUM(F_NUM), .LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bwrite    (bwrite),
        .ks        (ks),
        .ng        (ng),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .wr_en     (wr_en),
        .wr_bias   (wr_bias),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    wr_t  exp_q[$];
    logic done_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bdat(input int k);
        logic [63:0] d;
        for (int l = 0; l < LANES; l++) begin
            d[l*DW +: DW] = 16'(32'hA000 + k * 16 + l);
        end
        return d;
    endfunction

    // Monitor: a beat accepted in the previous cycle must show up as a write now,
    // and any other cycle must have wr_en low.
    logic acc_pend = 1'b0;
    wr_t  mon_e;
    logic mon_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_pend = 1'b0;
        end else begin
            if (acc_pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got wr_en %0h expected no write", wr_en);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_en", 64'(wr_en), 64'(mon_e.en));
                    chk("wr_bias", 64'(wr_bias), 64'(mon_e.bias));
                    chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    chk("wr_data", wr_data, mon_e.data);
                end
            end else begin
                chk("wr_en_idle", 64'(wr_en), 64'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done 1 expected 0");
                end else begin
                    mon_d = done_q.pop_front();
                    chk("err_at_done", 64'(err), 64'(mon_d));
                end
            end
            acc_pend = src_valid && src_ready;
        end
    end

    // Presents one beat and holds it until accepted; returns at accept edge + 1.
    task automatic send_beat(input logic [63:0] d, input logic last, input wr_t e);
        bit got = 0;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = last;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (src_ready) begin
                exp_q.push_back(e);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got src_ready 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic do_start(input logic bw, input int ks_v, input int ng_v);
        @(posedge clk);
        #1;
        start  = 1'b1;
        bwrite = bw;
        ks     = AW'(ks_v);
        ng     = 2'(ng_v);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ready_after_start", 64'(src_ready), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_cleared_by_start", 64'(err), 64'd0);
    endtask

    task automatic send_beats(input logic bw, input int ks_v, input int nsend,
                              input int last_at, input logic exp_err, input bit gaps);
        int  per;
        wr_t e;
        per = bw ? 1 : ks_v + 1;
        for (int k = 0; k < nsend; k++) begin
            if (gaps && ($urandom_range(0, 1) != 0)) begin
                src_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            e.en   = 16'(16'hF << (4 * (k / per)));
            e.bias = bw;
            e.addr = AW'(bw ? 0 : k % per);
            e.data = bdat(k);
            if (k == nsend - 1) done_q.push_back(exp_err);
            send_beat(bdat(k), k == last_at, e);
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    task automatic run_load(input logic bw, input int ks_v, input int ng_v, input int nsend,
                            input int last_at, input logic exp_err, input bit gaps);
        do_start(bw, ks_v, ng_v);
        send_beats(bw, ks_v, nsend, last_at, exp_err, gaps);
        chk("ready_in_drain", 64'(src_ready), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        chk("err_at_end", 64'(err), 64'(exp_err));
        @(posedge clk);
        #1;
        chk("idle_after_drain", 64'(busy), 64'd0);
        chk("done_single_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #3;
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_bias", 64'(wr_bias), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        #9 rst_n = 1'b1;

        // Weight load: 3 words per core, 4 groups, clean framing.
        run_load(1'b0, 2, 3, 12, 11, 1'b0, 0);
        // Bias load over 2 groups; ks is irrelevant in bias mode.
        run_load(1'b1, 5, 1, 2, 1, 1'b0, 0);
        // Early src_last on beat 5.
        run_load(1'b0, 2, 3, 5, 4, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_early_last", 64'(busy), 64'd0);
        // Missing src_last on beat 12.
        run_load(1'b0, 2, 3, 12, -1, 1'b1, 0);
        // Random valid gaps; the next start also clears the error left above.
        run_load(1'b0, 2, 3, 12, 11, 1'b0, 1);

        // Reset in the cycle where beat 6 is being written.
        do_start(1'b0, 2, 3);
        send_beats(1'b0, 2, 6, -1, 1'b0, 0);
        void'(done_q.pop_back());
        chk("wr_en_before_reset", 64'(wr_en), 64'h00F0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'd0);
        chk("async_rst_src_ready", 64'(src_ready), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset_ready", 64'(src_ready), 64'd0);
        chk("idle_after_reset_busy", 64'(busy), 64'd0);
        run_load(1'b0, 2, 3, 12, 11, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("writes_all_seen", 64'(exp_q.size()), 64'd0);
        chk("dones_all_seen", 64'(done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no end of test expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
